ahb_lite_bus_n: RTL and testbench

//  Parametrised AHB-lite single-master interconnect: decodes master address to NS slaves via

---
 rtl/ahb_lite_bus_n_pkg.sv | 10 +
 rtl/ahb_lite_bus_n_default_slave.sv | 24 ++
 rtl/ahb_lite_bus_n.sv | 83 ++++++++
 tb/tb_ahb_lite_bus_n.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ahb_lite_bus_n_pkg.sv
// ahb_pkg: AHB-lite transfer/response encodings and default-slave states.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
endpackage

// File: rtl/ahb_lite_bus_n_default_slave.sv
// ahb_default_slave: answers active unmapped transfers with a two-cycle ERROR, IDLE/BUSY with OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HREADYOUT,
  output logic       HRESP
);
  ds_state_t state, state_nxt;
  logic active;
  assign active = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state <= DS_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = (state == DS_ERR1) ? DS_ERR2 : (HREADY && HSEL && active) ? DS_ERR1 : DS_IDLE;
    HREADYOUT = state != DS_ERR1;
    HRESP     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  end
endmodule

// File: rtl/ahb_lite_bus_n.sv
// ahb_lite_bus_n: single-master AHB-lite decoder/response mux with default slave and sticky error log.
module ahb_lite_bus_n
  import ahb_pkg::*;
#(
  parameter int NS = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] S_BASE = '0,
  parameter logic [NS*AW-1:0] S_MASK = {NS{{4'hF, {(AW-4){1'b0}}}}}
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [AW-1:0]    HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  output logic             HREADY,
  output logic [DW-1:0]    HRDATA,
  output logic             HRESP,
  output logic [NS-1:0]    S_HSEL,
  input  logic [NS*DW-1:0] S_HRDATA,
  input  logic [NS-1:0]    S_HREADYOUT,
  input  logic [NS-1:0]    S_HRESP,
  output logic             ERR_VALID,
  output logic [AW-1:0]    ERR_ADDR,
  output logic             ERR_WRITE,
  input  logic             ERR_CLR
);
  localparam int DSW = $clog2(NS + 1);
  localparam logic [DSW-1:0] DEF = DSW'(NS);
  logic [NS-1:0]  hsel;
  logic [DSW-1:0] dec_idx, dsel;
  logic [AW-1:0]  a_addr;
  logic           a_write, ds_ready, ds_resp, cap;
  // Scan from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hsel    = '0;
    dec_idx = DEF;
    for (int i = NS - 1; i >= 0; i--)
      if ((HADDR & S_MASK[i*AW +: AW]) == S_BASE[i*AW +: AW]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
        dec_idx = DSW'(i);
      end
  end
  assign S_HSEL = hsel;
  ahb_default_slave u_def (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(dec_idx == DEF), .HTRANS(HTRANS),
    .HREADY(HREADY), .HREADYOUT(ds_ready), .HRESP(ds_resp)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dsel    <= DEF;
      a_addr  <= '0;
      a_write <= 1'b0;
    end else if (HREADY) begin
      dsel    <= dec_idx;
      a_addr  <= HADDR;
      a_write <= HWRITE;
    end
  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    for (int i = 0; i < NS; i++)
      if (dsel == DSW'(i)) begin
        HRDATA = S_HRDATA[i*DW +: DW];
        HREADY = S_HREADYOUT[i];
        HRESP  = S_HRESP[i];
      end
  end
  // A capture in the same cycle as a clear wins, so the log is never lost.
  assign cap = HREADY && HRESP && (!ERR_VALID || ERR_CLR);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
      ERR_WRITE <= 1'b0;
    end else if (cap) begin
      ERR_VALID <= 1'b1;
      ERR_ADDR  <= a_addr;
      ERR_WRITE <= a_write;
    end else if (ERR_CLR) ERR_VALID <= 1'b0;
endmodule

// File: tb/tb_ahb_lite_bus_n.sv
// tb_ahb_lite_bus_n: directed checks of decode, wait states, default-slave ERROR and error log.
// Map: S0 0x0/0xD800_0000 (also hits 0x2000_0000), S1 0x1, S2 0x2, S3 0x3 (mask 0xF000_0000).
module tb_ahb_lite_bus_n;
  import ahb_pkg::*;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite, hready, hresp, err_valid, err_write, err_clr;
  logic [31:0]  hrdata, err_addr;
  logic [3:0]   s_hsel, s_ready, s_resp;
  logic [127:0] s_rdata;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ahb_lite_bus_n #(
    .NS(4), .AW(32), .DW(32),
    .S_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .S_MASK({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hD800_0000})
  ) dut (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp), .S_HSEL(s_hsel),
    .S_HRDATA(s_rdata), .S_HREADYOUT(s_ready), .S_HRESP(s_resp),
    .ERR_VALID(err_valid), .ERR_ADDR(err_addr), .ERR_WRITE(err_write), .ERR_CLR(err_clr)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0; err_clr = 1'b0;
    s_ready = 4'hF; s_resp = '0; s_rdata = '0;
    @(negedge clk);
    chk("rst_ready", hready, 1); chk("rst_resp", hresp, 0); chk("rst_rdata", hrdata, 0);
    chk("rst_valid", err_valid, 0); chk("rst_addr", err_addr, 0); chk("rst_write", err_write, 0);
    step; rst_n = 1'b1;
    haddr = 32'h0000_0010; htrans = HTRANS_NONSEQ;
    @(negedge clk); chk("s0_hsel", s_hsel, 4'b0001);
    step; htrans = HTRANS_IDLE; s_rdata[31:0] = 32'h1234_5678;
    @(negedge clk); chk("s0_rdata", hrdata, 32'h1234_5678); chk("s0_ready", hready, 1);
    step; s_rdata = '0;
    haddr = 32'h1000_0004; htrans = HTRANS_NONSEQ;
    @(negedge clk); chk("s1_hsel", s_hsel, 4'b0010);
    step; htrans = HTRANS_IDLE; haddr = '0; s_ready = 4'b1101;
    @(negedge clk); chk("s1_wait1", hready, 0);
    step;
    @(negedge clk); chk("s1_wait2", hready, 0);
    step; s_ready = 4'hF; s_rdata[63:32] = 32'hCAFE_F00D;
    @(negedge clk); chk("s1_ready", hready, 1); chk("s1_rdata", hrdata, 32'hCAFE_F00D);
    chk("s1_resp", hresp, 0);
    step; s_rdata = '0;
    haddr = 32'h5000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    @(negedge clk); chk("um_hsel", s_hsel, 4'b0000);
    step; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    @(negedge clk); chk("um_err1_ready", hready, 0); chk("um_err1_resp", hresp, 1);
    chk("um_err1_valid", err_valid, 0);
    step;
    @(negedge clk); chk("um_err2_ready", hready, 1); chk("um_err2_resp", hresp, 1);
    step;
    @(negedge clk); chk("um_valid", err_valid, 1); chk("um_addr", err_addr, 32'h5000_0000);
    chk("um_write", err_write, 1); chk("um_okay", hresp, 0);
    step; haddr = 32'h5000_0000; htrans = HTRANS_NONSEQ;
    step; haddr = 32'h6000_0000;
    @(negedge clk); chk("b2b_err1a", {hready, hresp}, 2'b01);
    step;
    @(negedge clk); chk("b2b_err2a", {hready, hresp}, 2'b11);
    step; htrans = HTRANS_IDLE; haddr = '0;
    @(negedge clk); chk("b2b_err1b", {hready, hresp}, 2'b01);
    step;
    @(negedge clk); chk("b2b_err2b", {hready, hresp}, 2'b11);
    step;
    @(negedge clk); chk("b2b_addr", err_addr, 32'h5000_0000); chk("b2b_write", err_write, 1);
    chk("b2b_okay", hresp, 0);
    step; err_clr = 1'b1;
    step; err_clr = 1'b0;
    @(negedge clk); chk("clr_valid", err_valid, 0);
    step; haddr = 32'h6000_0004; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    step; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    step;
    step;
    @(negedge clk); chk("third_valid", err_valid, 1); chk("third_addr", err_addr, 32'h6000_0004);
    chk("third_write", err_write, 1);
    step; err_clr = 1'b1;
    step; err_clr = 1'b0; haddr = 32'h7000_0000; htrans = HTRANS_IDLE;
    @(negedge clk); chk("idle_hsel", s_hsel, 4'b0000);
    step; haddr = 32'h2000_0000;
    @(negedge clk); chk("idle_um_resp", {hready, hresp}, 2'b10); chk("ovl_hsel", s_hsel, 4'b0001);
    step;
    @(negedge clk); chk("idle_um_valid", err_valid, 0);
    step; haddr = 32'h2800_0000; htrans = HTRANS_NONSEQ;
    @(negedge clk); chk("s2_hsel", s_hsel, 4'b0100);
    step; htrans = HTRANS_IDLE; haddr = '0; s_ready = 4'b1011; s_resp = 4'b0100;
    @(negedge clk); chk("s2_err1", {hready, hresp}, 2'b01);
    step; s_ready = 4'hF; err_clr = 1'b1;
    @(negedge clk); chk("s2_err2", {hready, hresp}, 2'b11);
    step; err_clr = 1'b0; s_resp = '0;
    @(negedge clk); chk("s2_valid", err_valid, 1); chk("s2_addr", err_addr, 32'h2800_0000);
    chk("s2_write", err_write, 0);
    step; haddr = 32'h9000_0000; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    step; htrans = HTRANS_IDLE; haddr = '0; hwrite = 1'b0;
    step; err_clr = 1'b1;
    step; err_clr = 1'b0;
    @(negedge clk); chk("clrcap_valid", err_valid, 1); chk("clrcap_addr", err_addr, 32'h9000_0000);
    chk("clrcap_write", err_write, 1);
    step; haddr = 32'h1000_0004; htrans = HTRANS_NONSEQ;
    step; htrans = HTRANS_IDLE; haddr = '0; s_ready = 4'b1101; s_rdata[63:32] = 32'hDEAD_BEEF;
    @(negedge clk); chk("mid_wait", hready, 0);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_ready", hready, 1); chk("mid_rst_resp", hresp, 0);
    chk("mid_rst_rdata", hrdata, 0); chk("mid_rst_valid", err_valid, 0);
    chk("mid_rst_addr", err_addr, 0);
    step; rst_n = 1'b1; s_ready = 4'hF;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
